// File: rtl/upd78_intc.sv
// upd78_intc: prioritised interrupt controller with edge/level sources, mask register and SKIT-style test-and-clear.
// Define UPD78_INTC_NMI_EN to make source 0 non-maskable and independent of IE_I.
module upd78_intc #(
    parameter int              NSRC       = 5,
    parameter logic [NSRC-1:0] EDGE_MASK  = '1,
    parameter logic [15:0]     VEC_BASE   = 16'h0008,
    parameter logic [15:0]     VEC_STRIDE = 16'h0008
) (
    input  logic            CLK,
    input  logic            RESETB,
    input  logic            CP2_NEGEDGE,
    input  logic [NSRC-1:0] IRQ_I,
    input  logic            IE_I,
    input  logic            MK_WE,
    input  logic [NSRC-1:0] MK_D,
    output logic [NSRC-1:0] MK_Q,
    input  logic            INT_ACK,
    output logic            INT_REQ,
    output logic [3:0]      INT_ID,
    output logic [15:0]     INT_VEC,
    input  logic            TEST_STB,
    input  logic [3:0]      TEST_SEL,
    output logic            TEST_Q
);
    typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;
    state_t          state_q, state_d;
    logic [NSRC-1:0] s1_q, s2_q, prev_q, irr_q, irr_d, mk_q, mk_d;
    logic [NSRC-1:0] mk_eff, pend, elig, fall, clr;
    logic [3:0]      id_q, id_d, win;
    logic            test_q, test_d, hit;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= IRQ_I;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= IDLE;
            prev_q  <= '1;
            irr_q   <= '0;
            mk_q    <= '1;
            id_q    <= '0;
            test_q  <= 1'b0;
        end else if (CP2_NEGEDGE) begin
            state_q <= state_d;
            prev_q  <= s2_q;
            irr_q   <= irr_d;
            mk_q    <= mk_d;
            id_q    <= id_d;
            test_q  <= test_d;
        end
    end

`ifdef UPD78_INTC_NMI_EN
    assign mk_eff = mk_q & ~NSRC'(1);
    assign elig   = IE_I ? pend : (pend & NSRC'(1));
`else
    assign mk_eff = mk_q;
    assign elig   = IE_I ? pend : '0;
`endif
    assign pend = irr_q & ~mk_eff;
    assign fall = prev_q & ~s2_q & EDGE_MASK;

    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (elig[i]) win = 4'(i);
    end

    // Ack and test only ever clear edge sources; a fresh edge overrides the clear.
    always_comb begin
        clr = '0;
        hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            clr[i] = EDGE_MASK[i] & ((state_q == REQ && INT_ACK && id_q == 4'(i)) ||
                                     (TEST_STB && TEST_SEL == 4'(i)));
            if (TEST_SEL == 4'(i)) hit = irr_q[i];
        end
    end

    assign irr_d  = (EDGE_MASK & ((irr_q & ~clr) | fall)) | (~EDGE_MASK & ~s2_q);
    assign mk_d   = MK_WE ? MK_D : mk_q;
    assign test_d = TEST_STB ? hit : test_q;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = REQ;
                    id_d    = win;
                end
            end
            REQ: begin
                if (INT_ACK) state_d = ACKD;
                else if (!(|elig)) state_d = IDLE;
                else id_d = win;
            end
            default: state_d = IDLE;
        endcase
    end

    assign INT_REQ = (state_q == REQ);
    assign INT_ID  = id_q;
    assign INT_VEC = VEC_BASE + VEC_STRIDE * {12'b0, id_q};
    assign MK_Q    = mk_eff;
    assign TEST_Q  = test_q;
endmodule
